hsv_to_rgb: RTL

// - Inverse of the colour-detect hue path: converts a pixel from HSV back to 8-bit-per-channel RGB.
// - Hue uses the same unsigned fixed-point format (10.6, 60.0 = 16'h0F00) that the hue stages produce.
// - Drives the debug/overlay path so detected hue bands can be re-rendered as true colour.
// - 3-stage pipeline with valid/ready backpressure.
//

---
 rtl/hsv_to_rgb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: three-stage HSV -> RGB converter with valid/ready backpressure.
// Hue is unsigned 10.6 fixed-point degrees (60.0 = 16'h0F00); S, V and R/G/B are 8-bit.
// Stage 1 wraps the hue and finds sector/fraction. Stage 2 forms the p/q/t products.
// Stage 3 muxes the channels into the output register.
// Define HSV2RGB_RGB565_EN to pack o_data as 16-bit {R[7:3],G[7:2],B[7:3]} instead of 24-bit {R,G,B}.
module hsv_to_rgb (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_hue,
  input  logic [7:0]  i_sat,
  input  logic [7:0]  i_val,
  input  logic        i_valid,
  output logic        o_ready,
`ifdef HSV2RGB_RGB565_EN
  output logic [15:0] o_data,
`else
  output logic [23:0] o_data,
`endif
  output logic        o_valid,
  input  logic        i_ready
);

  typedef enum logic [2:0] {
    SEC0 = 3'd0,
    SEC1 = 3'd1,
    SEC2 = 3'd2,
    SEC3 = 3'd3,
    SEC4 = 3'd4,
    SEC5 = 3'd5
  } sector_e;

  // (a*b)>>8, truncating
  function automatic logic [7:0] mulhi(input logic [7:0] a, input logic [7:0] b);
    return 8'(({8'd0, a} * {8'd0, b}) >> 8);
  endfunction

  logic adv;

  // Whole pipeline moves together whenever the output slot is free or being drained
  always_comb begin
    adv     = !o_valid || i_ready;
    o_ready = adv && !i_rst;
  end

  // ---------------- Stage 1: wrap, sector, fraction ----------------
  logic [15:0] h_wrap;
  logic [15:0] sec_base;
  logic [11:0] rem_d;
  logic [7:0]  frac_d;
  sector_e     sec_d;

  logic        v1_q;
  sector_e     sec1_q;
  logic [7:0]  frac1_q;
  logic [7:0]  s1_q;
  logic [7:0]  val1_q;

  // Fold hue into 0..359.98 and split into 60-degree sector plus 8-bit fraction
  always_comb begin
    h_wrap = i_hue;
    if (i_hue >= 16'hB400)
      h_wrap = i_hue - 16'hB400;
    else if (i_hue >= 16'h5A00)
      h_wrap = i_hue - 16'h5A00;

    sec_d    = SEC0;
    sec_base = 16'h0000;
    if (h_wrap >= 16'h4B00) begin
      sec_d    = SEC5;
      sec_base = 16'h4B00;
    end else if (h_wrap >= 16'h3C00) begin
      sec_d    = SEC4;
      sec_base = 16'h3C00;
    end else if (h_wrap >= 16'h2D00) begin
      sec_d    = SEC3;
      sec_base = 16'h2D00;
    end else if (h_wrap >= 16'h1E00) begin
      sec_d    = SEC2;
      sec_base = 16'h1E00;
    end else if (h_wrap >= 16'h0F00) begin
      sec_d    = SEC1;
      sec_base = 16'h0F00;
    end

    rem_d  = 12'(h_wrap - sec_base);
    // 1092/16384 ~= 256/3840: scales 0..0x0EFF onto 0..255
    frac_d = 8'((23'(rem_d) * 23'd1092) >> 14);
  end

  // Stage 1 register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      sec1_q  <= SEC0;
      frac1_q <= '0;
      s1_q    <= '0;
      val1_q  <= '0;
    end else if (adv) begin
      v1_q    <= i_valid;
      sec1_q  <= sec_d;
      frac1_q <= frac_d;
      s1_q    <= i_sat;
      val1_q  <= i_val;
    end
  end

  // ---------------- Stage 2: p/q/t products ----------------
  logic [7:0] p_d;
  logic [7:0] q_d;
  logic [7:0] t_d;

  logic       v2_q;
  sector_e    sec2_q;
  logic [7:0] p2_q;
  logic [7:0] q2_q;
  logic [7:0] t2_q;
  logic [7:0] val2_q;
  logic       grey2_q;

  // 255-x is written as ~x on 8-bit operands
  always_comb begin
    p_d = mulhi(val1_q, ~s1_q);
    q_d = mulhi(val1_q, ~mulhi(s1_q, frac1_q));
    t_d = mulhi(val1_q, ~mulhi(s1_q, ~frac1_q));
  end

  // Stage 2 register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2_q    <= 1'b0;
      sec2_q  <= SEC0;
      p2_q    <= '0;
      q2_q    <= '0;
      t2_q    <= '0;
      val2_q  <= '0;
      grey2_q <= 1'b0;
    end else if (adv) begin
      v2_q    <= v1_q;
      sec2_q  <= sec1_q;
      p2_q    <= p_d;
      q2_q    <= q_d;
      t2_q    <= t_d;
      val2_q  <= val1_q;
      grey2_q <= (s1_q == 8'd0);
    end
  end

  // ---------------- Stage 3: channel mux and packing ----------------
  logic [7:0] r_d;
  logic [7:0] g_d;
  logic [7:0] b_d;
`ifdef HSV2RGB_RGB565_EN
  logic [15:0] pix_d;
`else
  logic [23:0] pix_d;
`endif

  // Zero saturation forces exact grey; p would otherwise be V*255>>8, not V
  always_comb begin
    r_d = val2_q;
    g_d = t2_q;
    b_d = p2_q;
    if (grey2_q) begin
      r_d = val2_q;
      g_d = val2_q;
      b_d = val2_q;
    end else begin
      unique case (sec2_q)
        SEC0: begin r_d = val2_q; g_d = t2_q;   b_d = p2_q;   end
        SEC1: begin r_d = q2_q;   g_d = val2_q; b_d = p2_q;   end
        SEC2: begin r_d = p2_q;   g_d = val2_q; b_d = t2_q;   end
        SEC3: begin r_d = p2_q;   g_d = q2_q;   b_d = val2_q; end
        SEC4: begin r_d = t2_q;   g_d = p2_q;   b_d = val2_q; end
        SEC5: begin r_d = val2_q; g_d = p2_q;   b_d = q2_q;   end
        default: begin r_d = val2_q; g_d = t2_q; b_d = p2_q;  end
      endcase
    end
`ifdef HSV2RGB_RGB565_EN
    pix_d = {5'(r_d >> 3), 6'(g_d >> 2), 5'(b_d >> 3)};
`else
    pix_d = {r_d, g_d, b_d};
`endif
  end

  // Output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (adv) begin
      o_valid <= v2_q;
      o_data  <= pix_d;
    end
  end

endmodule
